// File: rtl/tile_scheduler_if.sv
// Game controls in, VGA plot stream and score/status out, for tile_scheduler.
interface tile_scheduler_if;
    logic       start;
    logic [3:0] key_press;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot;
    logic [7:0] score;
    logic       game_over;
    logic       frame_done;

    modport master (
        input  start, key_press,
        output VGA_X, VGA_Y, VGA_COLOR, plot, score, game_over, frame_done
    );

    modport slave (
        output start, key_press,
        input  VGA_X, VGA_Y, VGA_COLOR, plot, score, game_over, frame_done
    );
endinterface

// File: rtl/tile_scheduler.sv
// Piano-tiles game sequencer: owns falling-tile state, scoring and miss detection,
// and sweeps the whole screen once per frame, driving the VGA plot interface.
module tile_scheduler #(
    parameter int RES_W         = 160,
    parameter int RES_H         = 120,
    parameter int ROW_H         = 30,
    parameter int SCROLL_FRAMES = 4
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    tile_scheduler_if.master bus
);

    localparam int NUM_SLOTS = 5;
    localparam int OFF_W     = $clog2(ROW_H + 1);
    localparam int FC_W      = $clog2(SCROLL_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        UPDATE
    } state_t;

    state_t state, state_n;

    logic [7:0]           x_cnt, x_cnt_n;
    logic [6:0]           y_cnt, y_cnt_n;
    logic [NUM_SLOTS-1:0] slot_valid, slot_valid_n;
    logic [NUM_SLOTS-1:0] slot_hit, slot_hit_n;
    logic [1:0]           slot_col   [NUM_SLOTS];
    logic [1:0]           slot_col_n [NUM_SLOTS];
    logic [OFF_W-1:0]     offset, offset_n;
    logic [FC_W-1:0]      frame_cnt, frame_cnt_n;
    logic [7:0]           lfsr;
    logic [7:0]           score_q, score_n;
    logic                 game_over_q, game_over_n;
    logic [7:0]           vga_x_q, vga_x_n;
    logic [6:0]           vga_y_q, vga_y_n;
    logic [2:0]           vga_color_q, vga_color_n;
    logic                 plot_q, plot_n;
    logic                 frame_done_q, frame_done_n;

    logic [1:0]           pix_col;
    logic                 pix_border;
    logic                 tile_here;
    logic                 tile_hit;
    logic [2:0]           pix_color;
    logic [9:0]           y_ext;

    logic                 restart;
    logic                 key_active;
    logic                 target4, target3;
    logic [1:0]           target_col;
    logic [NUM_SLOTS-1:0] key_hit_mask;
    logic                 key_score;
    logic                 key_fault;
    logic [NUM_SLOTS-1:0] hit_keyed;

    // Column decode; the three separator columns belong to no tile column.
    always_comb begin
        pix_col    = 2'd3;
        pix_border = 1'b0;
        if (x_cnt < 8'd39) begin
            pix_col = 2'd0;
        end else if (x_cnt == 8'd39) begin
            pix_border = 1'b1;
        end else if (x_cnt < 8'd79) begin
            pix_col = 2'd1;
        end else if (x_cnt == 8'd79) begin
            pix_border = 1'b1;
        end else if (x_cnt < 8'd119) begin
            pix_col = 2'd2;
        end else if (x_cnt == 8'd119) begin
            pix_border = 1'b1;
        end
    end

    // Slot s spans [s*ROW_H+offset-ROW_H, s*ROW_H+offset-1]; compared with y shifted by ROW_H to stay unsigned.
    assign y_ext = {3'b000, y_cnt} + 10'(ROW_H);

    always_comb begin
        tile_here = 1'b0;
        tile_hit  = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_valid[s] && !pix_border && (slot_col[s] == pix_col)
                && (y_ext >= 10'(s * ROW_H) + 10'(offset))
                && ({3'b000, y_cnt} < 10'(s * ROW_H) + 10'(offset))) begin
                tile_here = 1'b1;
                tile_hit  = slot_hit[s];
            end
        end
    end

    assign pix_color = tile_here  ? (tile_hit ? 3'b001 : 3'b000) :
                       pix_border ? 3'b010 : 3'b111;

    assign restart    = bus.start && ((state == IDLE) || game_over_q);
    assign key_active = (state != IDLE) && !game_over_q && (bus.key_press != 4'b0000);
    assign target4    = slot_valid[4] && !slot_hit[4];
    assign target3    = slot_valid[3] && !slot_hit[3];
    assign target_col = target4 ? slot_col[4] : slot_col[3];

    // Keys always judge the pre-scroll slots, so a hit in the shifting cycle rides along with its tile.
    always_comb begin
        key_hit_mask = '0;
        key_score    = 1'b0;
        key_fault    = 1'b0;
        if (key_active && (target4 || target3)) begin
            if (bus.key_press == (4'b0001 << target_col)) begin
                key_score = 1'b1;
                if (target4) begin
                    key_hit_mask[4] = 1'b1;
                end else begin
                    key_hit_mask[3] = 1'b1;
                end
            end else begin
                key_fault = 1'b1;
            end
        end
    end

    assign hit_keyed = slot_hit | key_hit_mask;

    always_comb begin
        state_n      = state;
        x_cnt_n      = x_cnt;
        y_cnt_n      = y_cnt;
        slot_valid_n = slot_valid;
        slot_hit_n   = slot_hit;
        slot_col_n   = slot_col;
        offset_n     = offset;
        frame_cnt_n  = frame_cnt;
        score_n      = score_q;
        game_over_n  = game_over_q;
        vga_x_n      = vga_x_q;
        vga_y_n      = vga_y_q;
        vga_color_n  = vga_color_q;
        plot_n       = 1'b0;
        frame_done_n = 1'b0;

        if (restart) begin
            state_n      = SWEEP;
            x_cnt_n      = '0;
            y_cnt_n      = '0;
            slot_valid_n = '0;
            slot_hit_n   = '0;
            slot_col_n   = '{default: 2'd0};
            offset_n     = '0;
            frame_cnt_n  = '0;
            score_n      = '0;
            game_over_n  = 1'b0;
        end else if (state == SWEEP || state == UPDATE) begin
            slot_hit_n = hit_keyed;
            if (key_score && (score_q != 8'hFF)) begin
                score_n = score_q + 8'd1;
            end
            if (key_fault) begin
                game_over_n = 1'b1;
            end

            if (state == SWEEP) begin
                plot_n      = 1'b1;
                vga_x_n     = x_cnt;
                vga_y_n     = y_cnt;
                vga_color_n = pix_color;
                if (x_cnt == 8'(RES_W - 1)) begin
                    x_cnt_n = '0;
                    if (y_cnt == 7'(RES_H - 1)) begin
                        y_cnt_n = '0;
                        state_n = UPDATE;
                    end else begin
                        y_cnt_n = y_cnt + 7'd1;
                    end
                end else begin
                    x_cnt_n = x_cnt + 8'd1;
                end
            end else begin
                frame_done_n = 1'b1;
                state_n      = SWEEP;
                x_cnt_n      = '0;
                y_cnt_n      = '0;
                if (!game_over_q) begin
                    if (frame_cnt == FC_W'(SCROLL_FRAMES - 1)) begin
                        frame_cnt_n = '0;
                        if (offset < OFF_W'(ROW_H - 1)) begin
                            offset_n = offset + OFF_W'(1);
                        end else begin
                            offset_n = '0;
                            if (slot_valid[4] && !hit_keyed[4]) begin
                                game_over_n = 1'b1;
                            end
                            for (int i = NUM_SLOTS - 1; i > 0; i--) begin
                                slot_valid_n[i] = slot_valid[i-1];
                                slot_col_n[i]   = slot_col[i-1];
                                slot_hit_n[i]   = hit_keyed[i-1];
                            end
                            slot_valid_n[0] = 1'b1;
                            slot_col_n[0]   = lfsr[1:0];
                            slot_hit_n[0]   = 1'b0;
                        end
                    end else begin
                        frame_cnt_n = frame_cnt + FC_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state        <= IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            slot_valid   <= '0;
            slot_hit     <= '0;
            slot_col     <= '{default: 2'd0};
            offset       <= '0;
            frame_cnt    <= '0;
            score_q      <= '0;
            game_over_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_color_q  <= '0;
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_n;
            x_cnt        <= x_cnt_n;
            y_cnt        <= y_cnt_n;
            slot_valid   <= slot_valid_n;
            slot_hit     <= slot_hit_n;
            slot_col     <= slot_col_n;
            offset       <= offset_n;
            frame_cnt    <= frame_cnt_n;
            score_q      <= score_n;
            game_over_q  <= game_over_n;
            vga_x_q      <= vga_x_n;
            vga_y_q      <= vga_y_n;
            vga_color_q  <= vga_color_n;
            plot_q       <= plot_n;
            frame_done_q <= frame_done_n;
        end
    end

    // Tile source runs in every state so the sequence depends on when the player starts.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign bus.VGA_X      = vga_x_q;
    assign bus.VGA_Y      = vga_y_q;
    assign bus.VGA_COLOR  = vga_color_q;
    assign bus.plot       = plot_q;
    assign bus.score      = score_q;
    assign bus.game_over  = game_over_q;
    assign bus.frame_done = frame_done_q;

endmodule
